// File: rtl/light_scheduler.sv
// light_scheduler: queues live/demo key codes and shows each for a fixed hold time followed by a dark gap
module light_scheduler #(
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       key_valid_i,
  input  logic [7:0] key_code_i,
  output logic       key_ready_o,
  input  logic       demo_valid_i,
  input  logic [7:0] demo_code_i,
  output logic       demo_ready_o,
  input  logic       clr_ovf_i,
  output logic [7:0] sel_out_o,
  output logic       busy_o,
  output logic       overflow_o
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [NW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sel_q, sel_d;
  logic          ovf_q, ovf_d;
  logic          push_live, push_demo, push, pop, drop;
  logic [7:0]    head, wdata;

  assign key_ready_o  = count_q != NW'(FIFO_DEPTH);
  assign demo_ready_o = !key_valid_i && count_q == '0 && state_q == IDLE;
  assign push_live    = key_valid_i && key_ready_o;
  assign push_demo    = demo_valid_i && demo_ready_o;
  assign push         = push_live || push_demo;
  assign drop         = key_valid_i && !key_ready_o;
  assign wdata        = push_live ? key_code_i : demo_code_i;
  assign head         = fifo_q[rd_q];
  assign count_d      = count_q + NW'(push) - NW'(pop);
  assign ovf_d        = drop || (ovf_q && !clr_ovf_i);
  assign sel_out_o    = sel_q;
  assign busy_o       = state_q != IDLE || count_q != '0;
  assign overflow_o   = ovf_q;

  // Display sequencing: pop a code into SHOW, count down hold then gap, chain or go idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:
        if (count_q != '0) begin
          pop     = 1'b1;
          sel_d   = head;
          cnt_d   = HOLD_LD;
          state_d = SHOW;
        end
      SHOW:
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (GAP_CYCLES > 0) begin
          sel_d   = '0;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else if (count_q != '0) begin
          pop   = 1'b1;
          sel_d = head;
          cnt_d = HOLD_LD;
        end else begin
          sel_d   = '0;
          state_d = IDLE;
        end
      GAP:
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (count_q != '0) begin
          pop     = 1'b1;
          sel_d   = head;
          cnt_d   = HOLD_LD;
          state_d = SHOW;
        end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, queue pointers/occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_d;
    end
  end

  // Queue storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (rstb && push) fifo_q[wr_q] <= wdata;
  end
endmodule

// File: tb/tb_light_scheduler.sv
// tb_light_scheduler: directed vector table plus randomized traffic against a slot-based reference model
module tb_light_scheduler;
  localparam int HOLD = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic       r, kv;
    logic [7:0] kc;
    logic       dv;
    logic [7:0] dc;
    logic       clr;
    logic [7:0] e_sel;
    logic       e_busy, e_kr, e_dr, e_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstb, key_valid, demo_valid, clr_ovf;
  logic [7:0] key_code, demo_code;
  logic       kr [2], dr [2], busy [2], ovf [2];
  logic [7:0] sel [2];

  logic [7:0] mq [2][$];
  int         left [2];
  logic [7:0] cur [2];
  logic       movf [2];
  int         mgap [2] = '{2, 0};

  int   checks = 0, errors = 0, cyc = 0;
  vec_t tab [$];

  always #5 clk = ~clk;

  light_scheduler #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstb(rstb), .key_valid_i(key_valid), .key_code_i(key_code), .key_ready_o(kr[0]),
    .demo_valid_i(demo_valid), .demo_code_i(demo_code), .demo_ready_o(dr[0]), .clr_ovf_i(clr_ovf),
    .sel_out_o(sel[0]), .busy_o(busy[0]), .overflow_o(ovf[0]));

  light_scheduler #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rstb(rstb), .key_valid_i(key_valid), .key_code_i(key_code), .key_ready_o(kr[1]),
    .demo_valid_i(demo_valid), .demo_code_i(demo_code), .demo_ready_o(dr[1]), .clr_ovf_i(clr_ovf),
    .sel_out_o(sel[1]), .busy_o(busy[1]), .overflow_o(ovf[1]));

  // Model view: each popped code owns a slot of HOLD+gap cycles, lit for the first HOLD of them
  function automatic logic [7:0] m_sel(int m);
    return left[m] > mgap[m] ? cur[m] : 8'h00;
  endfunction
  function automatic logic m_kr(int m);
    return mq[m].size() != DEPTH;
  endfunction
  function automatic logic m_dr(int m);
    return !key_valid && mq[m].size() == 0 && left[m] == 0;
  endfunction
  function automatic logic m_busy(int m);
    return left[m] != 0 || mq[m].size() != 0;
  endfunction

  task automatic upd(int m);
    logic kok, dok;
    if (!rstb) begin
      mq[m].delete();
      left[m] = 0;
      cur[m] = 8'h00;
      movf[m] = 1'b0;
    end else begin
      kok = key_valid && m_kr(m);
      dok = demo_valid && m_dr(m);
      movf[m] = (key_valid && !m_kr(m)) || (movf[m] && !clr_ovf);
      if (left[m] <= 1) begin
        if (mq[m].size() != 0) begin
          cur[m] = mq[m].pop_front();
          left[m] = HOLD + mgap[m];
        end else left[m] = 0;
      end else left[m]--;
      if (kok) mq[m].push_back(key_code);
      else if (dok) mq[m].push_back(demo_code);
    end
  endtask

  task automatic chk(string nm, int m, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, m, cyc, act, exp);
    end
  endtask

  task automatic mcheck();
    for (int m = 0; m < 2; m++) begin
      chk("sel", m, sel[m], m_sel(m));
      chk("busy", m, 8'(busy[m]), 8'(m_busy(m)));
      chk("key_ready", m, 8'(kr[m]), 8'(m_kr(m)));
      chk("demo_ready", m, 8'(dr[m]), 8'(m_dr(m)));
      chk("overflow", m, 8'(ovf[m]), 8'(movf[m]));
    end
  endtask

  task automatic drive(vec_t v);
    rstb = v.r;
    key_valid = v.kv;
    key_code = v.kc;
    demo_valid = v.dv;
    demo_code = v.dc;
    clr_ovf = v.clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    upd(0);
    upd(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(vec_t v, bit tabchk);
    drive(v);
    mcheck();
    if (tabchk) begin
      chk("tab_sel", 0, sel[0], v.e_sel);
      chk("tab_busy", 0, 8'(busy[0]), 8'(v.e_busy));
      chk("tab_key_ready", 0, 8'(kr[0]), 8'(v.e_kr));
      chk("tab_demo_ready", 0, 8'(dr[0]), 8'(v.e_dr));
      chk("tab_overflow", 0, 8'(ovf[0]), 8'(v.e_ovf));
    end
    tick();
  endtask

  function automatic vec_t mk(logic r, logic kv, logic [7:0] kc, logic dv, logic [7:0] dc, logic clr);
    return '{r, kv, kc, dv, dc, clr, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic add(int n, logic kv, logic [7:0] kc, logic dv, logic [7:0] dc, logic clr,
                     logic [7:0] es, logic eb, logic ekr, logic edr, logic eo);
    repeat (n) tab.push_back('{1'b1, kv, kc, dv, dc, clr, es, eb, ekr, edr, eo});
  endtask

  task automatic idle(int n);
    repeat (n) step(mk(1, 0, 0, 0, 0, 0), 1'b0);
  endtask

  initial begin
    vec_t v;
    rstb = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    demo_valid = 1'b0; demo_code = 8'h00; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    upd(0);
    upd(1);

    // reset state, then single key 'z': 4 lit, 2 dark, back to idle
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0);
    add(1, 1, 8'h7A, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
    add(4, 0, 8'h00, 0, 8'h00, 0, 8'h7A, 1, 1, 0, 0);
    add(2, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0);
    // live and demo together: live wins, demo waits for idle
    add(1, 1, 8'h62, 1, 8'h6E, 0, 8'h00, 0, 1, 0, 0);
    add(1, 0, 8'h00, 1, 8'h6E, 0, 8'h00, 1, 1, 0, 0);
    add(4, 0, 8'h00, 1, 8'h6E, 0, 8'h62, 1, 1, 0, 0);
    add(2, 0, 8'h00, 1, 8'h6E, 0, 8'h00, 1, 1, 0, 0);
    add(1, 0, 8'h00, 1, 8'h6E, 0, 8'h00, 0, 1, 1, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
    add(4, 0, 8'h00, 0, 8'h00, 0, 8'h6E, 1, 1, 0, 0);
    add(2, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0);
    // burst z s x d c v: v dropped; drop with clr keeps overflow, clr alone clears
    add(1, 1, 8'h7A, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    add(1, 1, 8'h73, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
    add(1, 1, 8'h78, 0, 8'h00, 0, 8'h7A, 1, 1, 0, 0);
    add(1, 1, 8'h64, 0, 8'h00, 0, 8'h7A, 1, 1, 0, 0);
    add(1, 1, 8'h63, 0, 8'h00, 0, 8'h7A, 1, 1, 0, 0);
    add(1, 1, 8'h76, 0, 8'h00, 0, 8'h7A, 1, 0, 0, 0);
    add(1, 1, 8'h71, 0, 8'h00, 1, 8'h00, 1, 0, 0, 1);
    add(1, 0, 8'h00, 0, 8'h00, 1, 8'h00, 1, 0, 0, 1);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'h73, 1, 1, 0, 0);
    foreach (tab[i]) step(tab[i], 1'b1);
    idle(30);

    // reset mid-SHOW with a full queue and overflow set
    for (int i = 0; i < 6; i++) step(mk(1, 1, 8'h41 + 8'(i), 0, 0, 0), 1'b0);
    step(mk(0, 0, 0, 0, 0, 0), 1'b0);
    v = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    step(v, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(mk(1, 0, 0, 0, 0, 0));
      mcheck();
      chk("post_reset_dark", 0, sel[0], 8'h00);
      tick();
    end

    // zero-gap instance: second code follows the first with no dark cycle
    step(mk(1, 1, 8'h41, 0, 0, 0), 1'b0);
    step(mk(1, 1, 8'h42, 0, 0, 0), 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(mk(1, 0, 0, 0, 0, 0));
      mcheck();
      chk("nogap_sel", 1, sel[1], i < 4 ? 8'h41 : i < 8 ? 8'h42 : 8'h00);
      tick();
    end

    for (int i = 0; i < 3000; i++)
      step(mk($urandom_range(0, 399) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
              $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 15) == 0), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
